mem_access_unit: RTL
====================

# mem_access_unit

Load/store initiator between the multicycle core's memory stage and the byte-enabled, synchronous-read data RAM. Accepts one load or store request at a time, generates the RAM's per-lane write enables and replicated write data, issues reads and waits out the RAM's one-cycle read latency. Returns extracted, sign- or zero-extended load data with a single-cycle response pulse. Byte order is big-endian: byte offset 0 is lane 3, bits [31:24].

## Interface
- ADDR_W, 16, byte address width; word index is ADDR_W-1:2.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- req_signed  in  1  loads: 1 sign-extend, 0 zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_error  out  1  misaligned access, valid with resp_valid.
- ram_address  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}.
- ram_isWrite  out  4  lane write enables; bit i covers bits [8i+7:8i].
- ram_writeData  out  32  lane-replicated store data.
- ram_isRead  out  1  read strobe.
- ram_byteRead  out  1  high with ram_isRead when size is byte.
- ram_data  in  32  RAM registered read data, valid the cycle after the read strobe.

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: req_ready=1. On req_valid, register write, size, signed, addr and wdata, then go to ISSUE.
- ISSUE: RAM outputs are driven combinationally from the registers for exactly this cycle. Store goes to RESP; load goes to CAPTURE.
- CAPTURE: select the lane(s) of ram_data, extend, and register into resp_rdata. Go to RESP.
- RESP: resp_valid=1, then return to IDLE. Outputs hold their values until the next response.
- Store enables by size and offset:
  - Byte: offset 0→1000, 1→0100, 2→0010, 3→0001.
  - Halfword: offset 0→1100, offset 2→0011.
  - Word: 1111.
- Store data: byte replicated {4{wdata[7:0]}}; halfword {2{wdata[15:0]}}; word unchanged.
- Load extraction:
  - Byte: offset k selects bits [31-8k:24-8k].
  - Halfword: offset 0 selects [31:16]; offset 2 selects [15:0].
  - Extension: by req_signed, using the MSB of the selected field.
- Outside ISSUE: ram_isWrite=0, ram_isRead=0, ram_byteRead=0. ram_address and ram_writeData hold the registered values.
- req_valid in any state other than IDLE is ignored.

## Timing
- Accept edge = T0.
  - Store: ram_isWrite is active in cycle T0+1; resp_valid in cycle T0+2.
  - Load: ram_isRead in T0+1, data captured at end of T0+2, resp_valid in T0+3.
- Peak throughput: one store per 3 cycles, one load per 4 cycles.
- Reset:
  - Reset values: state IDLE; req_ready=1 after reset release; resp_valid=0, resp_rdata=0, resp_error=0; all RAM strobes 0; registers cleared.
  - While reset is high, ram_isWrite and ram_isRead are forced to 0 combinationally, so a reset in ISSUE never writes.
  - Reset mid-operation drops the in-flight request with no response.

## Configuration
- MAU_MISALIGN_TRAP_EN defined:
  - Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]≠0.
  - A misaligned request goes IDLE→RESP with no RAM strobe; resp_valid=1 in T0+1 with resp_error=1 and resp_rdata=0.
- MAU_MISALIGN_TRAP_EN not defined:
  - Halfword ignores addr[0]; word ignores addr[1:0].
  - resp_error is tied to 0.

## Test plan
- Byte store 0xA5 to addr 0x0102 → cycle T0+1: ram_isWrite=0010, ram_writeData=0xA5A5A5A5, ram_address=0x0100; resp_valid at T0+2.
- RAM word 0x80FF7F01 at 0x0200; signed byte load at 0x0200 → resp_rdata=0xFFFFFF80 at T0+3; unsigned byte at 0x0201 → 0x000000FF.
- Signed halfword load at 0x0202, same word → 0x00007F01; at 0x0200 → 0xFFFF80FF.
- Halfword store 0x1234 at 0x0302 with word 0xDEADBEEF preloaded; word load at 0x0300 → 0xDEAD1234.
- Macro defined: word load at 0x0401 → resp_valid at T0+1, resp_error=1, resp_rdata=0, no ram_isRead pulse. Macro undefined: same request reads 0x0400, resp_error=0.
- Assert reset during the ISSUE cycle of a word store → ram_isWrite stays 0, target word unchanged, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for a byte-enabled sync-read RAM.
// Optional misaligned-access trap: define MAU_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_isWrite,
  output logic [31:0]       ram_writeData,
  output logic              ram_isRead,
  output logic              ram_byteRead,
  input  logic [31:0]       ram_data
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_error;

  logic        w_accept;
  logic        w_trap;
  logic        w_issue;
  logic        w_byte;
  logic        w_half;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [1:0]  w_bsel;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic [31:0] w_ext;

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_issue  = (r_state == ISSUE) && !reset;
  assign w_byte   = (r_size == 2'b00);
  assign w_half   = (r_size == 2'b01);

`ifdef MAU_MISALIGN_TRAP_EN
  assign w_trap = w_accept &&
    ((req_size == 2'b01 && req_addr[0]) ||
     (req_size[1] && req_addr[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state: trapped requests skip the RAM entirely
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = w_trap ? RESP : ISSUE;
      end
      ISSUE:   w_next = r_write ? RESP : CAPTURE;
      CAPTURE: w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture and response registers (held until next response)
  always_ff @(posedge clock) begin
    if (reset) begin
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_error  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (w_trap) begin
        r_rdata <= '0;
        r_error <= 1'b1;
      end
      if (r_state == ISSUE && r_write) begin
        r_rdata <= '0;
        r_error <= 1'b0;
      end
      if (r_state == CAPTURE) begin
        r_rdata <= w_ext;
        r_error <= 1'b0;
      end
    end
  end

  // Lane enables and replicated store data (big-endian lanes)
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    unique case (1'b1)
      w_byte: begin
        w_be    = 4'b1000 >> r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      w_half: begin
        w_be    = r_addr[1] ? 4'b0011 : 4'b1100;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and extension
  always_comb begin
    w_bsel = 2'd3 - r_addr[1:0];
    w_b    = ram_data[{w_bsel, 3'b000} +: 8];
    w_h    = r_addr[1] ? ram_data[15:0] : ram_data[31:16];
    w_ext  = ram_data;
    unique case (1'b1)
      w_byte:  w_ext = {{24{r_signed & w_b[7]}}, w_b};
      w_half:  w_ext = {{16{r_signed & w_h[15]}}, w_h};
      default: ;
    endcase
  end

  assign req_ready     = (r_state == IDLE);
  assign resp_valid    = (r_state == RESP);
  assign resp_rdata    = r_rdata;
  assign resp_error    = r_error;
  assign ram_address   = {r_addr[ADDR_W-1:2], 2'b00};
  assign ram_writeData = w_wdata;
  assign ram_isWrite   = (w_issue && r_write) ? w_be : 4'b0000;
  assign ram_isRead    = w_issue && !r_write;
  assign ram_byteRead  = ram_isRead && w_byte;

endmodule
